// File: rtl/gps_sample_pkg.sv
// gps_sample_pkg
//   Shared defaults and state encoding for the GPS sample unpacker.
//   DEF_WORD_WIDTH   : payload word width from the Ethernet receive path
//   DEF_SAMPLE_WIDTH : bits per emitted GPS sample
//   DEF_BUF_WIDTH    : reservoir depth, must be >= WORD + SAMPLE - 1
//   COUNT_WIDTH      : width of the bit_count port
//   unpack_state_t   : UNPACK_PRIME (waiting for first word) / UNPACK_RUN
package gps_sample_pkg;

  localparam int DEF_WORD_WIDTH   = 16;
  localparam int DEF_SAMPLE_WIDTH = 3;
  localparam int DEF_BUF_WIDTH    = 18;
  localparam int COUNT_WIDTH      = 5;

  typedef enum logic {
    UNPACK_PRIME = 1'b0,
    UNPACK_RUN   = 1'b1
  } unpack_state_t;

endpackage

// File: rtl/gps_sample_unpacker_bit_reservoir.sv
// bit_reservoir
//   MSB-aligned bit reservoir. Valid bits occupy the top 'count' positions,
//   the oldest bit at the MSB; all positions below the valid region are kept
//   at zero so an incoming word can be OR-ed in directly.
//   Ports:
//     clk, reset_n : clock, asynchronous active-low reset
//     clear        : synchronous clear (dominates load/consume)
//     load, word   : append word below the valid bits, MSB first
//     consume      : drop the SAMPLE_WIDTH oldest bits (applied before load)
//     top_bits     : the SAMPLE_WIDTH oldest bits
//     count        : number of valid bits held
module bit_reservoir
  import gps_sample_pkg::*;
#(
  parameter int WORD_WIDTH   = DEF_WORD_WIDTH,
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int BUF_WIDTH    = DEF_BUF_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    load,
  input  logic [WORD_WIDTH-1:0]   word,
  input  logic                    consume,
  output logic [SAMPLE_WIDTH-1:0] top_bits,
  output logic [COUNT_WIDTH-1:0]  count
);

  logic [BUF_WIDTH-1:0]   res_q, res_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic [BUF_WIDTH-1:0]   after_consume;
  logic [COUNT_WIDTH-1:0] count_after_consume;
  logic [BUF_WIDTH-1:0]   placed_word;

  always_comb begin
    after_consume       = res_q;
    count_after_consume = count_q;
    if (consume) begin
      after_consume       = res_q << SAMPLE_WIDTH;
      count_after_consume = count_q - COUNT_WIDTH'(SAMPLE_WIDTH);
    end
    // Word lands directly below the bits still held after the consume.
    placed_word = {word, {(BUF_WIDTH-WORD_WIDTH){1'b0}}} >> count_after_consume;
    res_d   = after_consume;
    count_d = count_after_consume;
    if (load) begin
      res_d   = after_consume | placed_word;
      count_d = count_after_consume + COUNT_WIDTH'(WORD_WIDTH);
    end
    if (clear) begin
      res_d   = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q   <= '0;
      count_q <= '0;
    end else begin
      res_q   <= res_d;
      count_q <= count_d;
    end
  end

  assign top_bits = res_q[BUF_WIDTH-1 -: SAMPLE_WIDTH];
  assign count    = count_q;

endmodule

// File: rtl/gps_sample_unpacker.sv
// gps_sample_unpacker
//   Turns 16-bit Ethernet payload words into a stream of 3-bit GPS samples,
//   one per sample_strobe, through an 18-bit bit reservoir.
//   Optional build macro: SAMPLE_UNPACK_STATS_EN enables the saturating
//   underflow event counter; without it underflow_count is tied to zero.
//   Ports:
//     clk, reset_n          : clock, asynchronous active-low reset
//     flush                 : synchronous clear of reservoir, back to PRIME
//     word_in, word_valid   : payload word input (bit 15 oldest)
//     word_ready            : word accepted this cycle when also valid
//     sample_strobe         : request for the next sample
//     sample_data           : registered sample
//     sample_valid          : one-cycle pulse, sample_data updated
//     bit_count             : valid bits held in the reservoir
//     underflow             : one-cycle pulse, strobe in RUN with too few bits
//     primed                : high in RUN (exposes the FSM state)
//     underflow_count       : saturating underflow count (optional)
//
//   Handshake: a word transfers on any rising edge where word_valid and
//   word_ready are both high. word_ready depends only on registered state
//   and flush, never on word_valid or sample_strobe; word_valid/word_in are
//   expected to hold until the transfer happens.
module gps_sample_unpacker
  import gps_sample_pkg::*;
#(
  parameter int WORD_WIDTH   = DEF_WORD_WIDTH,
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int BUF_WIDTH    = DEF_BUF_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic [WORD_WIDTH-1:0]   word_in,
  input  logic                    word_valid,
  output logic                    word_ready,
  input  logic                    sample_strobe,
  output logic [SAMPLE_WIDTH-1:0] sample_data,
  output logic                    sample_valid,
  output logic [4:0]              bit_count,
  output logic                    underflow,
  output logic                    primed,
  output logic [15:0]             underflow_count
);

  localparam logic [COUNT_WIDTH-1:0] LOAD_LIMIT = COUNT_WIDTH'(BUF_WIDTH - WORD_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] SAMPLE_MIN = COUNT_WIDTH'(SAMPLE_WIDTH);

  unpack_state_t state_q, state_d;

  logic                    load;
  logic                    consume;
  logic                    starve;
  logic [SAMPLE_WIDTH-1:0] top_bits;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= UNPACK_PRIME;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush)                                 state_d = UNPACK_PRIME;
    else if (state_q == UNPACK_PRIME && load)  state_d = UNPACK_RUN;
  end

  // Output / control decode. Underflow is judged on the pre-load count, so
  // a word arriving with the strobe never rescues it.
  always_comb begin
    primed     = (state_q == UNPACK_RUN);
    word_ready = !flush && (bit_count <= LOAD_LIMIT);
    load       = word_valid && word_ready;
    consume    = !flush && sample_strobe && primed && (bit_count >= SAMPLE_MIN);
    starve     = !flush && sample_strobe && primed && (bit_count <  SAMPLE_MIN);
  end

  bit_reservoir #(
    .WORD_WIDTH   (WORD_WIDTH),
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .BUF_WIDTH    (BUF_WIDTH)
  ) u_reservoir (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (flush),
    .load     (load),
    .word     (word_in),
    .consume  (consume),
    .top_bits (top_bits),
    .count    (bit_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      sample_valid <= consume;
      underflow    <= starve;
      if (flush)        sample_data <= '0;
      else if (consume) sample_data <= top_bits;
    end
  end

`ifdef SAMPLE_UNPACK_STATS_EN
  // Survives flush; only reset_n clears it.
  logic [15:0] underflow_count_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      underflow_count_q <= '0;
    else if (starve && underflow_count_q != 16'hFFFF)
      underflow_count_q <= underflow_count_q + 16'd1;
  end
  assign underflow_count = underflow_count_q;
`else
  assign underflow_count = 16'h0000;
`endif

`ifdef DEBUG
  a_count_bound: assert property (@(posedge clk) disable iff (!reset_n)
    bit_count <= COUNT_WIDTH'(BUF_WIDTH));
  a_load_room: assert property (@(posedge clk) disable iff (!reset_n)
    load |-> bit_count <= LOAD_LIMIT);
`endif

endmodule

// File: tb/tb_gps_sample_unpacker.sv
module tb_gps_sample_unpacker;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        flush;
  logic [15:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic        sample_strobe;
  logic [2:0]  sample_data;
  logic        sample_valid;
  logic [4:0]  bit_count;
  logic        underflow;
  logic        primed;
  logic [15:0] underflow_count;

  gps_sample_unpacker dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .flush           (flush),
    .word_in         (word_in),
    .word_valid      (word_valid),
    .word_ready      (word_ready),
    .sample_strobe   (sample_strobe),
    .sample_data     (sample_data),
    .sample_valid    (sample_valid),
    .bit_count       (bit_count),
    .underflow       (underflow),
    .primed          (primed),
    .underflow_count (underflow_count)
  );

  int total = 0;
  int bad   = 0;

  // reference model: the reservoir is a plain queue of bits, oldest first
  bit       m_bits[$];
  bit       m_run;
  bit [2:0] m_sdata;
  bit       m_svalid;
  bit       m_uf;
  int       m_ucount;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_bits.delete();
    m_run    = 1'b0;
    m_sdata  = 3'd0;
    m_svalid = 1'b0;
    m_uf     = 1'b0;
    m_ucount = 0;
  endfunction

  function automatic int exp_ucount();
`ifdef SAMPLE_UNPACK_STATS_EN
    return m_ucount;
`else
    return 0;
`endif
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_sd"}, 32'(sample_data),     32'(m_sdata));
    check({tag, "_sv"}, 32'(sample_valid),    32'(m_svalid));
    check({tag, "_uf"}, 32'(underflow),       32'(m_uf));
    check({tag, "_pr"}, 32'(primed),          32'(m_run));
    check({tag, "_bc"}, 32'(bit_count),       32'(m_bits.size()));
    check({tag, "_uc"}, 32'(underflow_count), 32'(exp_ucount()));
  endtask

  // driver: present inputs for one cycle, check ready, then check results
  task automatic cycle(input bit fl, input bit wv, input logic [15:0] w, input bit st);
    bit accept;
    flush         = fl;
    word_valid    = wv;
    word_in       = w;
    sample_strobe = st;
    #1;
    accept = !fl && (m_bits.size() <= 2);
    check("ready", 32'(word_ready), 32'(accept));
    @(posedge clk);
    #1;
    m_svalid = 1'b0;
    m_uf     = 1'b0;
    if (fl) begin
      m_bits.delete();
      m_run   = 1'b0;
      m_sdata = 3'd0;
    end else begin
      if (st && m_run) begin
        if (m_bits.size() >= 3) begin
          m_sdata[2] = m_bits.pop_front();
          m_sdata[1] = m_bits.pop_front();
          m_sdata[0] = m_bits.pop_front();
          m_svalid   = 1'b1;
        end else begin
          m_uf = 1'b1;
          if (m_ucount < 65535) m_ucount++;
        end
      end
      if (wv && accept) begin
        for (int i = 15; i >= 0; i--) m_bits.push_back(w[i]);
        m_run = 1'b1;
      end
    end
    check_outputs("cyc");
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic strobe();
    cycle(1'b0, 1'b0, 16'h0000, 1'b1);
  endtask

  task automatic load(input logic [15:0] w);
    cycle(1'b0, 1'b1, w, 1'b0);
  endtask

  logic [2:0] t1_exp[5];

  initial begin
    reset_n       = 1'b0;
    flush         = 1'b0;
    word_in       = '0;
    word_valid    = 1'b0;
    sample_strobe = 1'b0;
    model_reset();
    t1_exp = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3};

    #12;
    check_outputs("rst");
    check("rst_ready", 32'(word_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: FAC6 then five strobes -> 7,6,5,4,3, one bit left
    load(16'hFAC6);
    check("t1_primed", 32'(primed), 32'd1);
    for (int i = 0; i < 5; i++) begin
      strobe();
      check("t1_sample", 32'(sample_data), 32'(t1_exp[i]));
    end
    check("t1_bc", 32'(bit_count), 32'd1);

    // 2: append 8000, next sample spans the word boundary
    load(16'h8000);
    check("t2_bc_load", 32'(bit_count), 32'd17);
    strobe();
    check("t2_sample", 32'(sample_data), 32'd2);
    check("t2_bc", 32'(bit_count), 32'd14);

    // 3: strobes in PRIME are ignored
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      strobe();
      check("t3_sv", 32'(sample_valid), 32'd0);
      check("t3_uf", 32'(underflow), 32'd0);
    end
    check("t3_uc", 32'(underflow_count), 32'd0);

    // 4: underflow with a simultaneous word
    load(16'hFAC6);
    repeat (5) strobe();
    cycle(1'b0, 1'b1, 16'hFFFF, 1'b1);
    check("t4_uf", 32'(underflow), 32'd1);
    check("t4_sv", 32'(sample_valid), 32'd0);
    check("t4_sd", 32'(sample_data), 32'd3);
    check("t4_bc", 32'(bit_count), 32'd17);
`ifdef SAMPLE_UNPACK_STATS_EN
    check("t4_uc", 32'(underflow_count), 32'd1);
`else
    check("t4_uc", 32'(underflow_count), 32'd0);
`endif

    // 5: flush beats a pending word at bit_count=10
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    load(16'hFAC6);
    strobe();
    strobe();
    check("t5_bc_pre", 32'(bit_count), 32'd10);
    cycle(1'b1, 1'b1, 16'hFFFF, 1'b0);
    check("t5_bc", 32'(bit_count), 32'd0);
    check("t5_primed", 32'(primed), 32'd0);
    check("t5_sd", 32'(sample_data), 32'd0);
    idle();
    check("t5_bc_after", 32'(bit_count), 32'd0);

    // 6: long underflow run saturates the counter
    load(16'hFAC6);
    repeat (5) strobe();
    repeat (65540) strobe();
`ifdef SAMPLE_UNPACK_STATS_EN
    check("t6_uc_sat", 32'(underflow_count), 32'h0000FFFF);
`else
    check("t6_uc_zero", 32'(underflow_count), 32'd0);
`endif
    // flush keeps the count
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    check("t6_uc_flush", 32'(underflow_count), 32'(exp_ucount()));

    // asynchronous reset mid-cycle
    load(16'h1234);
    strobe();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("areset");
    @(negedge clk);
    reset_n = 1'b1;

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      cycle(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
            16'($urandom()), ($urandom_range(0, 2) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
